// File: rtl/axi_enhanced_tx_wrr_sched_pkg.sv
// Shared definitions for the TX weighted round-robin scheduler: channel codes,
// scheduler states, counter widths and small channel helpers.
package axi_enhanced_tx_wrr_sched_pkg;

  localparam logic [1:0] CH_RR  = 2'd0;
  localparam logic [1:0] CH_RW  = 2'd1;
  localparam logic [1:0] CH_CC  = 2'd2;
  localparam logic [1:0] CH_CFG = 2'd3;

  localparam int CREDIT_W = 4;
  localparam int CONSEC_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Throttle vector {cfg, cc, rw, rr}: only the granted channel is released.
  function automatic logic [3:0] thrtl_for(input logic [1:0] ch);
    return ~(4'b0001 << ch);
  endfunction

  // Cyclic successor over the three WRR channels RR->RW->CC->RR.
  function automatic logic [1:0] wrr_next(input logic [1:0] ch);
    return (ch == CH_CC) ? CH_RR : ch + 2'd1;
  endfunction

endpackage

// File: rtl/axi_enhanced_tx_wrr_sched_rr_pick.sv
// Next-requesting WRR channel search: scans pointer+1, pointer+2 and finally
// the pointer itself, so a lone requester is re-selected.
module axi_enhanced_tx_rr_pick
  import axi_enhanced_tx_wrr_sched_pkg::*;
(
  input  logic [1:0] ptr,
  input  logic [2:0] req,
  output logic       vld,
  output logic [1:0] ch
);

  logic [1:0] cand [3];

  assign cand[0] = wrr_next(ptr);
  assign cand[1] = wrr_next(cand[0]);
  assign cand[2] = ptr;

  // Walk from the farthest candidate down so the nearest requester wins.
  always_comb begin
    vld = 1'b0;
    ch  = ptr;
    for (int i = 2; i >= 0; i--) begin
      if (req[cand[i]]) begin
        vld = 1'b1;
        ch  = cand[i];
      end
    end
  end

endmodule

// File: rtl/axi_enhanced_tx_wrr_sched.sv
// Packet-boundary WRR scheduler for the shared TX path: RR/RW/CC share turns by
// weight, CFG gets bounded priority; a grant lasts one whole TLP.
module axi_enhanced_tx_wrr_sched
  import axi_enhanced_tx_wrr_sched_pkg::*;
#(
  parameter int W_RR           = 4,
  parameter int W_RW           = 4,
  parameter int W_CC           = 2,
  parameter int CFG_MAX_CONSEC = 2
) (
  input  logic       com_iclk,
  input  logic       com_sysrst_n,
  input  logic       s_axis_rr_tvalid,
  input  logic       s_axis_rw_tvalid,
  input  logic       s_axis_cc_tvalid,
  input  logic       s_axis_cfg_tvalid,
  input  logic       cfg_req,
  input  logic       s_axis_tx_tvalid,
  input  logic       s_axis_tx_tready,
  input  logic       s_axis_tx_tlast,
  input  logic       trn_lnk_up,
  output logic [1:0] channel_sel,
  output logic       grant_vld,
  output logic       rr_thrtl,
  output logic       rw_thrtl,
  output logic       cc_thrtl,
  output logic       cfg_thrtl
);

  localparam logic [CREDIT_W-1:0] WT_RR      = CREDIT_W'(W_RR);
  localparam logic [CREDIT_W-1:0] WT_RW      = CREDIT_W'(W_RW);
  localparam logic [CREDIT_W-1:0] WT_CC      = CREDIT_W'(W_CC);
  localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(CFG_MAX_CONSEC);

  function automatic logic [CREDIT_W-1:0] weight_of(input logic [1:0] ch);
    case (ch)
      CH_RR:   return WT_RR;
      CH_RW:   return WT_RW;
      default: return WT_CC;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [1:0]          channel_sel_q, channel_sel_d;
  logic                grant_vld_q, grant_vld_d;
  logic [3:0]          thrtl_q, thrtl_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CONSEC_W-1:0] consec_q, consec_d;

  logic [2:0]          wrr_req;
  logic                any_wrr;
  logic                eop;
  logic                pick_vld;
  logic [1:0]          pick_ch;
  logic [CREDIT_W-1:0] credit_eff;
  logic [CONSEC_W-1:0] consec_eff;
  logic                cfg_hi;
  logic                win_vld;
  logic [1:0]          win_ch;
  logic [1:0]          ptr_arb;
  logic [CREDIT_W-1:0] credit_arb;

  assign wrr_req = {s_axis_cc_tvalid, s_axis_rw_tvalid, s_axis_rr_tvalid};
  assign any_wrr = |wrr_req;
  assign eop     = (state_q == BUSY) & s_axis_tx_tvalid & s_axis_tx_tready & s_axis_tx_tlast;

  axi_enhanced_tx_rr_pick u_rr_pick (
    .ptr (ptr_q),
    .req (wrr_req),
    .vld (pick_vld),
    .ch  (pick_ch)
  );

  // Arbitration sees the counters as they will be after the finishing packet,
  // so the eop-cycle decision is the same function as the IDLE decision.
  always_comb begin
    credit_eff = credit_q;
    consec_eff = consec_q;
    if (eop) begin
      if (channel_sel_q == CH_CFG) begin
        if (consec_q != CONSEC_MAX) consec_eff = consec_q + 1'b1;
      end else begin
        consec_eff = '0;
        if (credit_q != '0) credit_eff = credit_q - 1'b1;
      end
    end

    cfg_hi     = cfg_req & s_axis_cfg_tvalid & ~((consec_eff == CONSEC_MAX) & any_wrr);
    win_vld    = 1'b0;
    win_ch     = CH_RR;
    ptr_arb    = ptr_q;
    credit_arb = credit_eff;
    if (cfg_hi) begin
      win_vld = 1'b1;
      win_ch  = CH_CFG;
    end else if (wrr_req[ptr_q] && (credit_eff != '0)) begin
      win_vld = 1'b1;
      win_ch  = ptr_q;
    end else if (pick_vld) begin
      win_vld    = 1'b1;
      win_ch     = pick_ch;
      ptr_arb    = pick_ch;
      credit_arb = weight_of(pick_ch);
    end else if (s_axis_cfg_tvalid) begin
      win_vld = 1'b1;
      win_ch  = CH_CFG;
    end
  end

  always_comb begin
    state_d       = state_q;
    channel_sel_d = channel_sel_q;
    grant_vld_d   = grant_vld_q;
    thrtl_d       = thrtl_q;
    ptr_d         = ptr_q;
    credit_d      = credit_q;
    consec_d      = consec_q;
    if (!trn_lnk_up) begin
      state_d     = FLUSH;
      grant_vld_d = 1'b0;
      thrtl_d     = 4'hF;
    end else begin
      case (state_q)
        FLUSH: begin
          state_d  = IDLE;
          ptr_d    = CH_RR;
          credit_d = WT_RR;
        end
        IDLE, BUSY: begin
          if ((state_q == IDLE) || eop) begin
            ptr_d    = ptr_arb;
            credit_d = credit_arb;
            consec_d = consec_eff;
            if (win_vld) begin
              state_d       = BUSY;
              channel_sel_d = win_ch;
              grant_vld_d   = 1'b1;
              thrtl_d       = thrtl_for(win_ch);
            end else begin
              state_d     = IDLE;
              grant_vld_d = 1'b0;
              thrtl_d     = 4'hF;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge com_iclk or negedge com_sysrst_n) begin
    if (!com_sysrst_n) begin
      state_q       <= IDLE;
      channel_sel_q <= CH_RR;
      grant_vld_q   <= 1'b0;
      thrtl_q       <= 4'hF;
      ptr_q         <= CH_RR;
      credit_q      <= WT_RR;
      consec_q      <= '0;
    end else begin
      state_q       <= state_d;
      channel_sel_q <= channel_sel_d;
      grant_vld_q   <= grant_vld_d;
      thrtl_q       <= thrtl_d;
      ptr_q         <= ptr_d;
      credit_q      <= credit_d;
      consec_q      <= consec_d;
    end
  end

  assign channel_sel = channel_sel_q;
  assign grant_vld   = grant_vld_q;
  assign rr_thrtl    = thrtl_q[0];
  assign rw_thrtl    = thrtl_q[1];
  assign cc_thrtl    = thrtl_q[2];
  assign cfg_thrtl   = thrtl_q[3];

endmodule

// File: tb/tb_axi_enhanced_tx_wrr_sched.sv
// Directed scoreboard bench for the TX WRR scheduler: expected grant channels
// are queued with the stimulus and popped as each grant appears.
module tb_axi_enhanced_tx_wrr_sched;
  import axi_enhanced_tx_wrr_sched_pkg::*;

  logic       com_iclk = 1'b0;
  logic       com_sysrst_n = 1'b1;
  logic       s_axis_rr_tvalid = 1'b0;
  logic       s_axis_rw_tvalid = 1'b0;
  logic       s_axis_cc_tvalid = 1'b0;
  logic       s_axis_cfg_tvalid = 1'b0;
  logic       cfg_req = 1'b0;
  logic       s_axis_tx_tvalid = 1'b0;
  logic       s_axis_tx_tready = 1'b0;
  logic       s_axis_tx_tlast = 1'b0;
  logic       trn_lnk_up = 1'b1;
  logic [1:0] channel_sel;
  logic       grant_vld;
  logic       rr_thrtl, rw_thrtl, cc_thrtl, cfg_thrtl;

  int         vectors = 0;
  int         miscompares = 0;
  logic [1:0] exp_q [$];
  logic [1:0] e;

  axi_enhanced_tx_wrr_sched #(
    .W_RR(4), .W_RW(4), .W_CC(2), .CFG_MAX_CONSEC(2)
  ) dut (
    .com_iclk          (com_iclk),
    .com_sysrst_n      (com_sysrst_n),
    .s_axis_rr_tvalid  (s_axis_rr_tvalid),
    .s_axis_rw_tvalid  (s_axis_rw_tvalid),
    .s_axis_cc_tvalid  (s_axis_cc_tvalid),
    .s_axis_cfg_tvalid (s_axis_cfg_tvalid),
    .cfg_req           (cfg_req),
    .s_axis_tx_tvalid  (s_axis_tx_tvalid),
    .s_axis_tx_tready  (s_axis_tx_tready),
    .s_axis_tx_tlast   (s_axis_tx_tlast),
    .trn_lnk_up        (trn_lnk_up),
    .channel_sel       (channel_sel),
    .grant_vld         (grant_vld),
    .rr_thrtl          (rr_thrtl),
    .rw_thrtl          (rw_thrtl),
    .cc_thrtl          (cc_thrtl),
    .cfg_thrtl         (cfg_thrtl)
  );

  always #5 com_iclk = ~com_iclk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge com_iclk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] outs();
    return {1'b0, grant_vld, channel_sel, cfg_thrtl, cc_thrtl, rw_thrtl, rr_thrtl};
  endfunction

  task automatic clear_reqs();
    s_axis_rr_tvalid = 1'b0; s_axis_rw_tvalid = 1'b0; s_axis_cc_tvalid = 1'b0;
    s_axis_cfg_tvalid = 1'b0; cfg_req = 1'b0;
  endtask

  task automatic reset_dut();
    clear_reqs();
    s_axis_tx_tvalid = 1'b0; s_axis_tx_tready = 1'b0; s_axis_tx_tlast = 1'b0;
    trn_lnk_up = 1'b1;
    com_sysrst_n = 1'b0;
    #1;
    chk("rst_async", outs(), 8'b0_0_00_1111);
    step(); step();
    com_sysrst_n = 1'b1;
    step();
  endtask

  task automatic check_grant(input string tag, output logic [1:0] ch);
    ch = 2'b00;
    chk({tag, "_gv"}, {7'd0, grant_vld}, 8'd1);
    chk({tag, "_sb"}, {7'd0, exp_q.size() != 0}, 8'd1);
    if (exp_q.size() != 0) begin
      ch = exp_q.pop_front();
      chk({tag, "_sel"}, {6'd0, channel_sel}, {6'd0, ch});
      chk({tag, "_thrtl"}, {4'd0, cfg_thrtl, cc_thrtl, rw_thrtl, rr_thrtl},
          {4'd0, 4'hF ^ (4'd1 << ch)});
      $display("grant %s: channel_sel=%0d grant_vld=%0b expected_ch=%0d", tag, channel_sel, grant_vld, ch);
    end
  endtask

  // Grant must already be visible; drives one packet and optionally removes
  // every request together with its last beat.
  task automatic do_pkt(input string tag, input int beats, input bit drop);
    logic [1:0] ch;
    check_grant(tag, ch);
    for (int b = 1; b <= beats; b++) begin
      if (drop && b == beats) clear_reqs();
      s_axis_tx_tvalid = 1'b1; s_axis_tx_tready = 1'b1; s_axis_tx_tlast = (b == beats);
      step();
      if (b < beats) chk({tag, "_hold"}, {5'd0, grant_vld, channel_sel}, {5'd0, 1'b1, ch});
    end
    s_axis_tx_tvalid = 1'b0; s_axis_tx_tlast = 1'b0;
  endtask

  initial begin
    step();
    // Reset and quiet idle
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t1_idle", outs(), 8'b0_0_00_1111);
    end

    // Weighted rotation 4/4/2 with 1-beat packets, back to back
    for (int r = 0; r < 2; r++) begin
      repeat (4) exp_q.push_back(CH_RR);
      repeat (4) exp_q.push_back(CH_RW);
      repeat (2) exp_q.push_back(CH_CC);
    end
    s_axis_rr_tvalid = 1'b1; s_axis_rw_tvalid = 1'b1; s_axis_cc_tvalid = 1'b1;
    step();
    for (int p = 0; p < 20; p++) do_pkt("t2_wrr", 1, p == 19);
    chk("t2_idle", {7'd0, grant_vld}, 8'd0);

    // CFG priority waits for the RR packet boundary; stalled tlast is not eop
    reset_dut();
    s_axis_rr_tvalid = 1'b1;
    exp_q.push_back(CH_RR); exp_q.push_back(CH_CFG);
    step();
    check_grant("t3_rr", e);
    for (int b = 1; b <= 5; b++) begin
      if (b == 2) begin cfg_req = 1'b1; s_axis_cfg_tvalid = 1'b1; end
      if (b == 3) s_axis_rr_tvalid = 1'b0;
      s_axis_tx_tvalid = 1'b1; s_axis_tx_tready = (b != 4); s_axis_tx_tlast = (b >= 4);
      step();
      if (b < 5) chk("t3_hold", {5'd0, grant_vld, channel_sel}, {5'd0, 1'b1, CH_RR});
    end
    s_axis_tx_tvalid = 1'b0; s_axis_tx_tlast = 1'b0;
    do_pkt("t3_cfg", 1, 1'b1);
    chk("t3_idle", {7'd0, grant_vld}, 8'd0);

    // Bounded CFG priority: two CFG then one forced RW
    reset_dut();
    cfg_req = 1'b1; s_axis_cfg_tvalid = 1'b1; s_axis_rw_tvalid = 1'b1;
    exp_q.push_back(CH_CFG); exp_q.push_back(CH_CFG); exp_q.push_back(CH_RW);
    exp_q.push_back(CH_CFG); exp_q.push_back(CH_CFG); exp_q.push_back(CH_RW);
    step();
    for (int p = 0; p < 6; p++) do_pkt("t4_cfg", 1, p == 5);
    chk("t4_idle", {7'd0, grant_vld}, 8'd0);

    // Link drop mid CC packet, then restart from RR with full credit
    reset_dut();
    s_axis_cc_tvalid = 1'b1;
    exp_q.push_back(CH_CC);
    step();
    check_grant("t5_cc", e);
    for (int b = 1; b <= 3; b++) begin
      if (b == 3) trn_lnk_up = 1'b0;
      s_axis_tx_tvalid = 1'b1; s_axis_tx_tready = 1'b1; s_axis_tx_tlast = 1'b0;
      step();
    end
    s_axis_tx_tvalid = 1'b0;
    chk("t5_flush", outs() & 8'h4F, 8'b0_0_00_1111);
    step(); step();
    chk("t5_flush_hold", outs() & 8'h4F, 8'b0_0_00_1111);
    trn_lnk_up = 1'b1; s_axis_rr_tvalid = 1'b1;
    repeat (4) exp_q.push_back(CH_RR);
    exp_q.push_back(CH_CC);
    step();
    chk("t5_to_idle", {7'd0, grant_vld}, 8'd0);
    step();
    for (int p = 0; p < 5; p++) do_pkt("t5_relink", 1, p == 4);
    chk("t5_idle", {7'd0, grant_vld}, 8'd0);

    // Lone CC requester re-selected with reloaded credit
    reset_dut();
    s_axis_cc_tvalid = 1'b1;
    repeat (3) exp_q.push_back(CH_CC);
    step();
    do_pkt("t6_cc", 2, 1'b0);
    do_pkt("t6_cc", 1, 1'b0);
    do_pkt("t6_cc", 1, 1'b1);
    chk("t6_idle", {7'd0, grant_vld}, 8'd0);

    // Asynchronous reset in the middle of a packet
    reset_dut();
    s_axis_rr_tvalid = 1'b1;
    exp_q.push_back(CH_RR);
    step();
    check_grant("t7_rr", e);
    s_axis_tx_tvalid = 1'b1; s_axis_tx_tready = 1'b1; s_axis_tx_tlast = 1'b0;
    step();
    chk("t7_hold", {5'd0, grant_vld, channel_sel}, {5'd0, 1'b1, CH_RR});
    com_sysrst_n = 1'b0;
    #1;
    chk("t7_async_rst", outs(), 8'b0_0_00_1111);
    step();
    clear_reqs();
    s_axis_tx_tvalid = 1'b0;
    com_sysrst_n = 1'b1;
    step();

    chk("sb_empty", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
